// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Assembles UART bytes into read/write command frames, drives the memory_map
// request/ack handshake, and returns a status byte (plus read data) to the
// UART transmitter. Single clock domain (clk210_p).
//
// Ports:
//   clk210_p, reset_p        clock, synchronous active-high reset
//   rx_data_p, rx_valid_p    received byte + one-cycle strobe
//   tx_data_p, tx_valid_p    byte to transmit, held until tx_ready_p
//   tx_ready_p               transmitter accepts the byte
//   memory_map_*             address/write data/requests out, read data,
//                            byte count, acks and error in
//   busy_p                   high whenever the parser is not idle
module uart_cmd_parser #(
  parameter logic [7:0]  CMD_WR       = 8'h57,
  parameter logic [7:0]  CMD_RD       = 8'h52,
  parameter int unsigned ACK_TIMEOUT  = 1024,
  parameter int unsigned BYTE_TIMEOUT = 2100000
) (
  input  logic        clk210_p,
  input  logic        reset_p,
  input  logic [7:0]  rx_data_p,
  input  logic        rx_valid_p,
  output logic [7:0]  tx_data_p,
  output logic        tx_valid_p,
  input  logic        tx_ready_p,
  output logic [15:0] memory_map_adrs_p,
  output logic [15:0] memory_map_wr_data_p,
  output logic        memory_map_wr_req_p,
  output logic        memory_map_rd_req_p,
  input  logic [79:0] memory_map_rd_data_p,
  input  logic [3:0]  memory_map_num_bytes_p,
  input  logic        memory_map_rd_ack_p,
  input  logic        memory_map_wr_ack_p,
  input  logic        memory_map_er_p,
  output logic        busy_p
);

  localparam int unsigned TMAX = (BYTE_TIMEOUT > ACK_TIMEOUT) ? BYTE_TIMEOUT : ACK_TIMEOUT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);

  localparam logic [7:0] ST_OK  = 8'h4B;
  localparam logic [7:0] ST_ERR = 8'h45;
  localparam logic [7:0] ST_TMO = 8'h54;

  typedef enum logic [3:0] {
    IDLE, ADRS_HI, ADRS_LO, DATA_HI, DATA_LO, REQ, WAIT_ACK, SEND_STATUS, SEND_DATA
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic          is_write;
  logic [7:0]    status, status_next;
  logic [79:0]   rd_sr;
  logic [3:0]    count;
  logic [15:0]   adrs, wr_data;
  logic          ack_match, latch_rd, byte_tmo;

  assign memory_map_adrs_p    = adrs;
  assign memory_map_wr_data_p = wr_data;
  assign busy_p               = (state != IDLE);

  always_comb begin
    state_next          = state;
    status_next         = status;
    latch_rd            = 1'b0;
    tx_valid_p          = 1'b0;
    tx_data_p           = '0;
    memory_map_wr_req_p = 1'b0;
    memory_map_rd_req_p = 1'b0;
    ack_match           = is_write ? memory_map_wr_ack_p : memory_map_rd_ack_p;
    byte_tmo            = (timer == BYTE_LAST);
    case (state)
      IDLE: begin
        if (rx_valid_p && (rx_data_p == CMD_WR || rx_data_p == CMD_RD)) state_next = ADRS_HI;
      end
      ADRS_HI: begin
        if (rx_valid_p)    state_next = ADRS_LO;
        else if (byte_tmo) state_next = IDLE;
      end
      ADRS_LO: begin
        if (rx_valid_p)    state_next = is_write ? DATA_HI : REQ;
        else if (byte_tmo) state_next = IDLE;
      end
      DATA_HI: begin
        if (rx_valid_p)    state_next = DATA_LO;
        else if (byte_tmo) state_next = IDLE;
      end
      DATA_LO: begin
        if (rx_valid_p)    state_next = REQ;
        else if (byte_tmo) state_next = IDLE;
      end
      // The request is already visible in REQ, so a same-cycle response from
      // memory_map is honoured there too rather than being lost.
      REQ, WAIT_ACK: begin
        memory_map_wr_req_p = is_write;
        memory_map_rd_req_p = !is_write;
        if (memory_map_er_p) begin
          status_next = ST_ERR;
          state_next  = SEND_STATUS;
        end else if (ack_match) begin
          status_next = ST_OK;
          state_next  = SEND_STATUS;
          latch_rd    = !is_write;
        end else if (state == WAIT_ACK && timer == ACK_LAST) begin
          status_next = ST_TMO;
          state_next  = SEND_STATUS;
        end else begin
          state_next  = WAIT_ACK;
        end
      end
      SEND_STATUS: begin
        tx_valid_p = 1'b1;
        tx_data_p  = status;
        if (tx_ready_p)
          state_next = (!is_write && status == ST_OK && count != 4'd0) ? SEND_DATA : IDLE;
      end
      SEND_DATA: begin
        tx_valid_p = 1'b1;
        tx_data_p  = rd_sr[79:72];
        if (tx_ready_p && count == 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      state    <= IDLE;
      timer    <= '0;
      is_write <= 1'b0;
      status   <= '0;
      rd_sr    <= '0;
      count    <= '0;
      adrs     <= '0;
      wr_data  <= '0;
    end else begin
      state  <= state_next;
      status <= status_next;
      // One timer serves both the inter-byte and the ack timeout; the last
      // frame byte clears it so REQ starts the ack wait from zero.
      case (state)
        ADRS_HI, ADRS_LO, DATA_HI, DATA_LO: timer <= rx_valid_p ? '0 : timer + TW'(1);
        REQ, WAIT_ACK:                      timer <= timer + TW'(1);
        default:                            timer <= '0;
      endcase
      if (state == IDLE && state_next == ADRS_HI) is_write <= (rx_data_p == CMD_WR);
      if (rx_valid_p && (state == ADRS_HI || state == ADRS_LO)) adrs <= {adrs[7:0], rx_data_p};
      if (rx_valid_p && (state == DATA_HI || state == DATA_LO)) wr_data <= {wr_data[7:0], rx_data_p};
      if (latch_rd) begin
        rd_sr <= memory_map_rd_data_p;
        count <= (memory_map_num_bytes_p > 4'd10) ? 4'd10 : memory_map_num_bytes_p;
      end else if (state == SEND_DATA && tx_ready_p) begin
        rd_sr <= {rd_sr[71:0], 8'h00};
        count <= count - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: scenario tasks with randomized frames, checked
// against a response model built from the frame/outcome rules.
module tb_uart_cmd_parser;

  localparam int unsigned BT = 100;
  localparam int unsigned AT = 1024;

  logic        clk210_p = 1'b0;
  logic        reset_p = 1'b1;
  logic [7:0]  rx_data_p = '0;
  logic        rx_valid_p = 1'b0;
  logic [7:0]  tx_data_p;
  logic        tx_valid_p;
  logic        tx_ready_p = 1'b0;
  logic [15:0] memory_map_adrs_p;
  logic [15:0] memory_map_wr_data_p;
  logic        memory_map_wr_req_p;
  logic        memory_map_rd_req_p;
  logic [79:0] memory_map_rd_data_p = '0;
  logic [3:0]  memory_map_num_bytes_p = '0;
  logic        memory_map_rd_ack_p = 1'b0;
  logic        memory_map_wr_ack_p = 1'b0;
  logic        memory_map_er_p = 1'b0;
  logic        busy_p;

  uart_cmd_parser #(.ACK_TIMEOUT(AT), .BYTE_TIMEOUT(BT)) dut (
    .clk210_p(clk210_p), .reset_p(reset_p),
    .rx_data_p(rx_data_p), .rx_valid_p(rx_valid_p),
    .tx_data_p(tx_data_p), .tx_valid_p(tx_valid_p), .tx_ready_p(tx_ready_p),
    .memory_map_adrs_p(memory_map_adrs_p), .memory_map_wr_data_p(memory_map_wr_data_p),
    .memory_map_wr_req_p(memory_map_wr_req_p), .memory_map_rd_req_p(memory_map_rd_req_p),
    .memory_map_rd_data_p(memory_map_rd_data_p), .memory_map_num_bytes_p(memory_map_num_bytes_p),
    .memory_map_rd_ack_p(memory_map_rd_ack_p), .memory_map_wr_ack_p(memory_map_wr_ack_p),
    .memory_map_er_p(memory_map_er_p), .busy_p(busy_p)
  );

  always #5 clk210_p = ~clk210_p;

  int         checks = 0;
  int         errors = 0;
  int         ready_mode = 0;
  int         hold_viol = 0;
  int         overlap = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] tx_got[$];
  logic [7:0] exp_q[$];

  // Advance to the next falling edge, record accepted tx bytes, watch for
  // stalled bytes that change, then choose tx_ready for the coming cycle.
  task automatic tick();
    @(negedge clk210_p);
    if (prev_stall && !(tx_valid_p === 1'b1 && tx_data_p === prev_data)) hold_viol++;
    if (memory_map_wr_req_p === 1'b1 && memory_map_rd_req_p === 1'b1) overlap++;
    case (ready_mode)
      0:       tx_ready_p = 1'b1;
      1:       tx_ready_p = ~tx_ready_p;
      default: tx_ready_p = 1'($urandom_range(0, 1));
    endcase
    if (tx_valid_p === 1'b1 && tx_ready_p === 1'b1) tx_got.push_back(tx_data_p);
    prev_stall = (tx_valid_p === 1'b1) && !tx_ready_p;
    prev_data  = tx_data_p;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_p  = b;
    rx_valid_p = 1'b1;
    tick();
    rx_valid_p = 1'b0;
  endtask

  // Reference: status byte for the outcome, then for a good read the first
  // min(num_bytes,10) bytes of rd_data, most significant byte first.
  task automatic model_response(input bit is_wr, input int outcome, input logic [79:0] rdd,
                                input int nb);
    int n;
    exp_q.delete();
    if (outcome == 0)      exp_q.push_back(8'h4B);
    else if (outcome == 1) exp_q.push_back(8'h45);
    else                   exp_q.push_back(8'h54);
    if (!is_wr && outcome == 0) begin
      n = (nb > 10) ? 10 : nb;
      for (int i = 0; i < n; i++) exp_q.push_back(rdd[79-8*i -: 8]);
    end
  endtask

  // outcome: 0 = matching ack, 1 = er together with ack, 2 = no response.
  task automatic do_frame(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                          input int outcome, input int delay, input logic [79:0] rdd,
                          input logic [3:0] nb, input bit noise, input int gap_max,
                          input string name);
    logic [7:0] frame[$];
    int  hi, bad, hv0, want_hi;
    bit  done, finished;
    logic req_now, req_other;
    tx_got.delete();
    hv0 = hold_viol;
    memory_map_rd_data_p   = rdd;
    memory_map_num_bytes_p = nb;
    frame = '{is_wr ? 8'h57 : 8'h52, a[15:8], a[7:0]};
    if (is_wr) begin
      frame.push_back(d[15:8]);
      frame.push_back(d[7:0]);
    end
    foreach (frame[k]) begin
      repeat ($urandom_range(0, gap_max)) tick();
      send_byte(frame[k]);
    end
    req_now   = is_wr ? memory_map_wr_req_p : memory_map_rd_req_p;
    req_other = is_wr ? memory_map_rd_req_p : memory_map_wr_req_p;
    checks++;
    if (req_now !== 1'b1 || req_other !== 1'b0)
      $display("FAIL %s req_after_last_byte got %b/%b want 1/0", name, req_now, req_other);
    if (req_now !== 1'b1 || req_other !== 1'b0) errors++;
    hi = 0; bad = 0; done = 0; finished = 0;
    for (int g = 0; g < 3000; g++) begin
      memory_map_wr_ack_p = 1'b0;
      memory_map_rd_ack_p = 1'b0;
      memory_map_er_p     = 1'b0;
      rx_valid_p          = 1'b0;
      if (!done) begin
        req_now = is_wr ? memory_map_wr_req_p : memory_map_rd_req_p;
        if (req_now === 1'b1) begin
          hi++;
          if (memory_map_adrs_p !== a || (is_wr && memory_map_wr_data_p !== d)) bad++;
          if (outcome != 2 && hi == delay) begin
            memory_map_er_p = (outcome == 1);
            if (is_wr) memory_map_wr_ack_p = 1'b1;
            else       memory_map_rd_ack_p = 1'b1;
          end else if (hi == 2 && delay > 3) begin
            if (is_wr) memory_map_rd_ack_p = 1'b1;
            else       memory_map_wr_ack_p = 1'b1;
          end
          if (noise && hi == 3) begin
            rx_valid_p = 1'b1;
            rx_data_p  = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
          end
        end else begin
          done = 1;
        end
      end else if (busy_p === 1'b0) begin
        finished = 1;
        break;
      end
      tick();
    end
    memory_map_wr_ack_p = 1'b0;
    memory_map_rd_ack_p = 1'b0;
    memory_map_er_p     = 1'b0;
    rx_valid_p          = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s completion got busy=%b want idle within budget", name, busy_p);
    end
    want_hi = (outcome == 2) ? int'(AT) : delay;
    checks++;
    if (hi !== want_hi) begin
      errors++;
      $display("FAIL %s req_cycles got %0d want %0d", name, hi, want_hi);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s adrs_data_stable got %0d bad cycles want 0", name, bad);
    end
    model_response(is_wr, outcome, rdd, int'(nb));
    checks++;
    if (tx_got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s tx_count got %0d want %0d", name, tx_got.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        checks++;
        if (tx_got[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL %s tx_byte[%0d] got %h want %h", name, k, tx_got[k], exp_q[k]);
        end
      end
    end
    checks++;
    if (hold_viol - hv0 !== 0) begin
      errors++;
      $display("FAIL %s tx_hold got %0d violations want 0", name, hold_viol - hv0);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    repeat (3) tick();
    checks++;
    if ({tx_valid_p, tx_data_p, memory_map_wr_req_p, memory_map_rd_req_p, busy_p} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ctrl got %b%h%b%b%b want all 0", tx_valid_p, tx_data_p,
               memory_map_wr_req_p, memory_map_rd_req_p, busy_p);
    end
    checks++;
    if ({memory_map_adrs_p, memory_map_wr_data_p} !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got %h %h want 0 0", memory_map_adrs_p, memory_map_wr_data_p);
    end
    reset_p = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy_p !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy got %b want 0", busy_p);
    end
  endtask

  task automatic test_write();
    ready_mode = 0;
    do_frame(1'b1, 16'h0012, 16'hABCD, 0, 5, '0, 4'd0, 1'b0, 0, "write");
  endtask

  task automatic test_read();
    ready_mode = 1;
    do_frame(1'b0, 16'h0004, 16'h0000, 0, 6, 80'h0102030405060708090A, 4'd3, 1'b0, 0, "read");
  endtask

  task automatic test_error_timeout();
    ready_mode = 2;
    do_frame(1'b0, 16'hFFFF, 16'h0000, 1, 4, 80'h1122334455667788990A, 4'd5, 1'b0, 0, "error");
    do_frame(1'b0, 16'hFFFF, 16'h0000, 2, 0, 80'h1122334455667788990A, 4'd5, 1'b0, 0, "timeout");
  endtask

  task automatic test_frame_abort();
    bit req_seen;
    ready_mode = 0;
    tx_got.delete();
    req_seen = 0;
    send_byte(8'h57);
    send_byte(8'h00);
    for (int i = 1; i <= int'(BT); i++) begin
      tick();
      if (memory_map_wr_req_p === 1'b1 || memory_map_rd_req_p === 1'b1) req_seen = 1;
      if (i == int'(BT) - 1) begin
        checks++;
        if (busy_p !== 1'b1) begin
          errors++;
          $display("FAIL abort_before_limit busy got %b want 1", busy_p);
        end
      end
      if (i == int'(BT)) begin
        checks++;
        if (busy_p !== 1'b0) begin
          errors++;
          $display("FAIL abort_at_limit busy got %b want 0", busy_p);
        end
      end
    end
    checks++;
    if (req_seen || tx_got.size() != 0) begin
      errors++;
      $display("FAIL abort_quiet got req=%b tx=%0d want req=0 tx=0", req_seen, tx_got.size());
    end
    do_frame(1'b0, 16'h0001, 16'h0000, 0, 3, 80'hA1A2A3A4A5A6A7A8A9AA, 4'd2, 1'b0, 0, "after_abort");
  endtask

  task automatic test_noise();
    ready_mode = 0;
    tx_got.delete();
    send_byte(8'h00);
    checks++;
    if (busy_p !== 1'b0) begin
      errors++;
      $display("FAIL noise_00 busy got %b want 0", busy_p);
    end
    send_byte(8'h41);
    checks++;
    if (busy_p !== 1'b0) begin
      errors++;
      $display("FAIL noise_41 busy got %b want 0", busy_p);
    end
    repeat (3) tick();
    checks++;
    if (tx_got.size() != 0) begin
      errors++;
      $display("FAIL noise_tx got %0d bytes want 0", tx_got.size());
    end
    ready_mode = 2;
    do_frame(1'b0, 16'h1234, 16'h0000, 0, 8, 80'hF0E1D2C3B4A596877869, 4'd15, 1'b1, 1, "clamp_noise");
    do_frame(1'b1, 16'h5678, 16'h9ABC, 0, 4, '0, 4'd0, 1'b0, 1, "after_noise");
  endtask

  task automatic test_random();
    logic [95:0] r96;
    int r, outcome, delay;
    bit is_wr;
    for (int n = 0; n < 24; n++) begin
      is_wr   = 1'($urandom_range(0, 1));
      r       = $urandom_range(0, 9);
      outcome = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      delay   = $urandom_range(2, 20);
      r96     = {$urandom, $urandom, $urandom};
      ready_mode = $urandom_range(0, 2);
      do_frame(is_wr, 16'($urandom), 16'($urandom), outcome, delay, r96[79:0],
               4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) && delay >= 4, 5, "random");
    end
  endtask

  task automatic test_reset_midop();
    ready_mode = 0;
    tx_got.delete();
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h08);
    repeat (3) tick();
    checks++;
    if (memory_map_rd_req_p !== 1'b1) begin
      errors++;
      $display("FAIL midop_req_pending got %b want 1", memory_map_rd_req_p);
    end
    reset_p = 1'b1;
    tick();
    checks++;
    if ({memory_map_rd_req_p, busy_p, tx_valid_p} !== 3'b000) begin
      errors++;
      $display("FAIL midop_reset got req/busy/txv %b%b%b want 000", memory_map_rd_req_p, busy_p,
               tx_valid_p);
    end
    reset_p = 1'b0;
    prev_stall = 1'b0;
    repeat (10) tick();
    checks++;
    if (tx_got.size() != 0 || busy_p !== 1'b0) begin
      errors++;
      $display("FAIL midop_after got tx=%0d busy=%b want tx=0 busy=0", tx_got.size(), busy_p);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error_timeout();
    test_frame_abort();
    test_noise();
    test_random();
    test_reset_midop();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL req_exclusive got %0d overlapping cycles want 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
